// File: rtl/axi_dac_jesd204_start_ctrl.sv
// JESD204 DAC start/stop sequencer: waits for a settled link, arms, aligns streaming
// start to a delayed trigger edge, and counts DMA underflows while running.
module axi_dac_jesd204_start_ctrl #(
   parameter int NUM_CHANNELS       = 2,
   parameter int LINK_SETTLE_CYCLES = 16,
   parameter int TRIG_DELAY_WIDTH   = 8
) (
   input  logic                        dac_clk,
   input  logic                        dac_rst,
   input  logic                        tx_ready,
   input  logic                        dac_arm,
   input  logic                        dac_disarm,
   input  logic                        dac_trig,
   input  logic                        dac_trig_bypass,
   input  logic [TRIG_DELAY_WIDTH-1:0] dac_trig_delay,
   input  logic [NUM_CHANNELS-1:0]     dac_enable_in,
   input  logic                        dac_dunf,
   input  logic                        dac_dunf_clr,
   output logic [NUM_CHANNELS-1:0]     dac_valid,
   output logic                        dac_data_en,
   output logic [2:0]                  dac_state,
   output logic                        dac_link_lost,
   output logic [15:0]                 dac_dunf_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LINK_WAIT = 3'd1,
      ARMED     = 3'd2,
      DELAY     = 3'd3,
      RUN       = 3'd4
   } state_t;

   localparam logic [15:0]                 SETTLE_LAST = 16'(LINK_SETTLE_CYCLES - 1);
   localparam logic [TRIG_DELAY_WIDTH-1:0] DELAY_ONE   = TRIG_DELAY_WIDTH'(1);

   state_t                      state_reg, state_next;
   logic [15:0]                 settle_reg, settle_next;
   logic [TRIG_DELAY_WIDTH-1:0] delay_reg, delay_next;
   logic                        trig_hist_reg;
   logic                        link_lost_reg, link_lost_next;
   logic [NUM_CHANNELS-1:0]     valid_reg, valid_next;
   logic                        data_en_reg;
   logic [15:0]                 dunf_reg;
   logic                        trig_edge;
   logic                        run_next;

   // History resets high so a trigger already asserted out of reset is not an edge.
   assign trig_edge = dac_trig & ~trig_hist_reg;
   assign run_next  = (state_next == RUN);

   always_comb begin
      state_next     = state_reg;
      settle_next    = settle_reg;
      delay_next     = delay_reg;
      link_lost_next = link_lost_reg;
      if (dac_disarm) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (dac_arm) begin
                  state_next     = LINK_WAIT;
                  settle_next    = 16'd0;
                  link_lost_next = 1'b0;
               end
            end
            LINK_WAIT: begin
               if (!tx_ready) begin
                  settle_next = 16'd0;
               end else if (settle_reg == SETTLE_LAST) begin
                  state_next  = ARMED;
                  settle_next = 16'd0;
               end else begin
                  settle_next = settle_reg + 16'd1;
               end
            end
            ARMED: begin
               if (!tx_ready) begin
                  state_next  = LINK_WAIT;
                  settle_next = 16'd0;
               end else if (dac_trig_bypass) begin
                  state_next = RUN;
               end else if (trig_edge) begin
                  if (dac_trig_delay == '0) begin
                     state_next = RUN;
                  end else begin
                     state_next = DELAY;
                     delay_next = dac_trig_delay - DELAY_ONE;
                  end
               end
            end
            DELAY: begin
               if (!tx_ready) begin
                  state_next     = IDLE;
                  link_lost_next = 1'b1;
               end else if (delay_reg == '0) begin
                  state_next = RUN;
               end else begin
                  delay_next = delay_reg - DELAY_ONE;
               end
            end
            RUN: begin
               if (!tx_ready) begin
                  state_next     = IDLE;
                  link_lost_next = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the RUN cycles.
   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_valid
         assign valid_next[gi] = run_next & dac_enable_in[gi];
      end
   endgenerate

   always_ff @(posedge dac_clk) begin
      if (dac_rst) begin
         state_reg     <= IDLE;
         settle_reg    <= 16'd0;
         delay_reg     <= '0;
         trig_hist_reg <= 1'b1;
         link_lost_reg <= 1'b0;
         valid_reg     <= '0;
         data_en_reg   <= 1'b0;
         dunf_reg      <= 16'd0;
      end else begin
         state_reg     <= state_next;
         settle_reg    <= settle_next;
         delay_reg     <= delay_next;
         trig_hist_reg <= dac_trig;
         link_lost_reg <= link_lost_next;
         valid_reg     <= valid_next;
         data_en_reg   <= run_next;
         if (dac_dunf_clr) begin
            dunf_reg <= 16'd0;
         end else if ((state_reg == RUN) && dac_dunf && (dunf_reg != 16'hFFFF)) begin
            dunf_reg <= dunf_reg + 16'd1;
         end
      end
   end

   assign dac_valid      = valid_reg;
   assign dac_data_en    = data_en_reg;
   assign dac_state      = state_reg;
   assign dac_link_lost  = link_lost_reg;
   assign dac_dunf_count = dunf_reg;

endmodule

// File: tb/tb_axi_dac_jesd204_start_ctrl.sv
// Directed bench for the JESD204 DAC start sequencer; expected values are hand-derived
// cycle counts from the settle length and trigger delay.
module tb_axi_dac_jesd204_start_ctrl;

   logic       dac_clk = 1'b0;
   logic       dac_rst;
   logic       tx_ready;
   logic       dac_arm;
   logic       dac_disarm;
   logic       dac_trig;
   logic       dac_trig_bypass;
   logic [7:0] dac_trig_delay;
   logic [1:0] dac_enable_in;
   logic       dac_dunf;
   logic       dac_dunf_clr;
   logic [1:0] dac_valid;
   logic       dac_data_en;
   logic [2:0] dac_state;
   logic       dac_link_lost;
   logic [15:0] dac_dunf_count;

   int tests_run    = 0;
   int tests_failed = 0;

   axi_dac_jesd204_start_ctrl #(
      .NUM_CHANNELS       (2),
      .LINK_SETTLE_CYCLES (16),
      .TRIG_DELAY_WIDTH   (8)
   ) dut (
      .dac_clk         (dac_clk),
      .dac_rst         (dac_rst),
      .tx_ready        (tx_ready),
      .dac_arm         (dac_arm),
      .dac_disarm      (dac_disarm),
      .dac_trig        (dac_trig),
      .dac_trig_bypass (dac_trig_bypass),
      .dac_trig_delay  (dac_trig_delay),
      .dac_enable_in   (dac_enable_in),
      .dac_dunf        (dac_dunf),
      .dac_dunf_clr    (dac_dunf_clr),
      .dac_valid       (dac_valid),
      .dac_data_en     (dac_data_en),
      .dac_state       (dac_state),
      .dac_link_lost   (dac_link_lost),
      .dac_dunf_count  (dac_dunf_count)
   );

   always #5 dac_clk = ~dac_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, act);
      end
   endtask

   // One clock; outputs are observed 1 ns after the edge, inputs change there too.
   task automatic step();
      @(posedge dac_clk);
      #1;
   endtask

   task automatic arm_and_settle();
      dac_arm = 1'b1;
      step();
      dac_arm = 1'b0;
      repeat (16) step();
      check("armed_after_settle", 32'(dac_state), 2);
   endtask

   // Produces a clean rising edge; returns with the edge cycle T consumed (now at T+1).
   task automatic trig_edge(input logic [7:0] dly);
      dac_trig = 1'b0;
      step();
      dac_trig       = 1'b1;
      dac_trig_delay = dly;
      step();
      dac_trig = 1'b0;
   endtask

   initial begin
      dac_rst         = 1'b1;
      tx_ready        = 1'b1;
      dac_arm         = 1'b0;
      dac_disarm      = 1'b0;
      dac_trig        = 1'b1;
      dac_trig_bypass = 1'b0;
      dac_trig_delay  = 8'd0;
      dac_enable_in   = 2'b11;
      dac_dunf        = 1'b0;
      dac_dunf_clr    = 1'b0;
      repeat (3) step();
      check("rst_state", 32'(dac_state), 0);
      check("rst_valid", 32'(dac_valid), 0);
      check("rst_data_en", 32'(dac_data_en), 0);
      check("rst_link_lost", 32'(dac_link_lost), 0);
      check("rst_dunf_count", 32'(dac_dunf_count), 0);
      dac_rst = 1'b0;
      step();

      // Settle: LINK_WAIT lasts exactly 16 cycles with tx_ready high.
      dac_arm = 1'b1;
      step();
      dac_arm = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("link_wait_c%0d", i), 32'(dac_state), 1);
         step();
      end
      check("armed_at_16", 32'(dac_state), 2);

      // Trigger held high since reset must not start anything.
      repeat (3) step();
      check("trig_held_no_start", 32'(dac_state), 2);

      // Delay 5: DELAY from T+1, RUN at T+6; later delay changes are ignored.
      trig_edge(8'd5);
      dac_trig_delay = 8'd9;
      check("delay5_t1_state", 32'(dac_state), 3);
      check("delay5_t1_data_en", 32'(dac_data_en), 0);
      for (int i = 2; i <= 5; i++) begin
         step();
         check($sformatf("delay5_t%0d_state", i), 32'(dac_state), 3);
      end
      step();
      check("delay5_t6_state", 32'(dac_state), 4);
      check("delay5_t6_valid", 32'(dac_valid), 2'b11);
      check("delay5_t6_data_en", 32'(dac_data_en), 1);

      // Underflow counting in RUN.
      dac_dunf = 1'b1;
      repeat (3) step();
      dac_dunf = 1'b0;
      check("dunf_count_3", 32'(dac_dunf_count), 3);

      // Enable change reaches dac_valid on the following edge.
      dac_enable_in = 2'b01;
      check("valid_before_edge", 32'(dac_valid), 2'b11);
      step();
      check("valid_follows_enable", 32'(dac_valid), 2'b01);

      // Clear wins over a coincident underflow.
      dac_dunf     = 1'b1;
      dac_dunf_clr = 1'b1;
      step();
      dac_dunf     = 1'b0;
      dac_dunf_clr = 1'b0;
      check("dunf_clr_wins", 32'(dac_dunf_count), 0);

      // Link loss in RUN.
      tx_ready = 1'b0;
      step();
      tx_ready = 1'b1;
      check("runloss_state", 32'(dac_state), 0);
      check("runloss_valid", 32'(dac_valid), 0);
      check("runloss_data_en", 32'(dac_data_en), 0);
      check("runloss_link_lost", 32'(dac_link_lost), 1);

      // Underflow outside RUN is ignored.
      dac_dunf = 1'b1;
      repeat (2) step();
      dac_dunf = 1'b0;
      check("dunf_idle_ignored", 32'(dac_dunf_count), 0);

      // Arm + disarm together stays idle and keeps the sticky flag.
      dac_arm    = 1'b1;
      dac_disarm = 1'b1;
      step();
      dac_arm    = 1'b0;
      dac_disarm = 1'b0;
      check("arm_disarm_idle", 32'(dac_state), 0);
      check("arm_disarm_lost_kept", 32'(dac_link_lost), 1);

      // Arm clears link_lost; disarm from LINK_WAIT.
      dac_arm = 1'b1;
      step();
      dac_arm = 1'b0;
      check("arm_state", 32'(dac_state), 1);
      check("arm_clears_lost", 32'(dac_link_lost), 0);
      repeat (2) step();
      dac_disarm = 1'b1;
      step();
      dac_disarm = 1'b0;
      check("disarm_link_wait", 32'(dac_state), 0);

      // tx_ready glitch at count 10 restarts the settle window.
      dac_arm = 1'b1;
      step();
      dac_arm = 1'b0;
      repeat (10) step();
      tx_ready = 1'b0;
      step();
      tx_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("resettle_c%0d", i), 32'(dac_state), 1);
         step();
      end
      check("resettle_armed", 32'(dac_state), 2);

      // Delay 0: RUN at T+1.
      trig_edge(8'd0);
      check("delay0_state", 32'(dac_state), 4);
      check("delay0_valid", 32'(dac_valid), 2'b01);
      check("delay0_data_en", 32'(dac_data_en), 1);

      // Saturation of the underflow counter.
      dac_dunf = 1'b1;
      repeat (65534) step();
      check("dunf_count_fffe", 32'(dac_dunf_count), 16'hFFFE);
      repeat (6) step();
      dac_dunf = 1'b0;
      check("dunf_saturates", 32'(dac_dunf_count), 16'hFFFF);

      // Disarm from RUN; counter survives disarm.
      dac_disarm = 1'b1;
      step();
      dac_disarm = 1'b0;
      check("disarm_run_state", 32'(dac_state), 0);
      check("disarm_run_valid", 32'(dac_valid), 0);
      check("disarm_run_data_en", 32'(dac_data_en), 0);
      check("disarm_run_lost", 32'(dac_link_lost), 0);
      check("disarm_keeps_dunf", 32'(dac_dunf_count), 16'hFFFF);

      // Bypass: RUN on the next cycle.
      arm_and_settle();
      dac_trig_bypass = 1'b1;
      step();
      dac_trig_bypass = 1'b0;
      check("bypass_run", 32'(dac_state), 4);
      dac_disarm = 1'b1;
      step();
      dac_disarm = 1'b0;

      // Disarm from ARMED.
      arm_and_settle();
      dac_disarm = 1'b1;
      step();
      dac_disarm = 1'b0;
      check("disarm_armed", 32'(dac_state), 0);

      // Disarm from DELAY.
      arm_and_settle();
      trig_edge(8'd5);
      check("in_delay", 32'(dac_state), 3);
      dac_disarm = 1'b1;
      step();
      dac_disarm = 1'b0;
      check("disarm_delay", 32'(dac_state), 0);

      // Link loss in DELAY sets the sticky flag.
      arm_and_settle();
      trig_edge(8'd5);
      tx_ready = 1'b0;
      step();
      tx_ready = 1'b1;
      check("delayloss_state", 32'(dac_state), 0);
      check("delayloss_lost", 32'(dac_link_lost), 1);

      // Link loss in ARMED returns to LINK_WAIT without the flag.
      arm_and_settle();
      tx_ready = 1'b0;
      step();
      tx_ready = 1'b1;
      check("armedloss_state", 32'(dac_state), 1);
      check("armedloss_lost", 32'(dac_link_lost), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/axi_dac_jesd204_start_ctrl.md
Name: axi_dac_jesd204_start_ctrl

Overview:
- Start/stop sequencer for the JESD204 DAC transmit datapath. Runs in the tx_clk/dac_clk domain, between the register map (arm/disarm/delay controls) and the DAC core/DMA handshake.
- Waits for a stable link, arms, then aligns the start of sample streaming to an external trigger with a programmable delay.
- Gates dac_valid and the datapath enable, drops back to idle on link loss, and counts DMA underflows while running.

Parameters:
NUM_CHANNELS, 2, number of DAC channels; width of the enable/valid vectors.
LINK_SETTLE_CYCLES, 16, consecutive tx_ready-high cycles needed before arming completes (1..65535).
TRIG_DELAY_WIDTH, 8, width of the trigger-to-start delay field.

Ports:
dac_clk  in  1  tx_clk (line-rate/40); the only clock.
dac_rst  in  1  synchronous, active-high reset.
tx_ready  in  1  JESD204 link ready.
dac_arm  in  1  one-cycle pulse: start the sequence (ignored unless IDLE).
dac_disarm  in  1  one-cycle pulse: abort to IDLE from any state.
dac_trig  in  1  external trigger, already synchronised to dac_clk.
dac_trig_bypass  in  1  1 = start without waiting for a trigger.
dac_trig_delay  in  TRIG_DELAY_WIDTH  cycles from trigger edge to RUN, minus one.
dac_enable_in  in  NUM_CHANNELS  per-channel enables from the register map.
dac_dunf  in  1  DMA underflow indication.
dac_dunf_clr  in  1  one-cycle pulse: clear the underflow counter.
dac_valid  out  NUM_CHANNELS  per-channel sample request toward the DMA.
dac_data_en  out  1  1 = datapath output live; 0 = core drives zero samples.
dac_state  out  3  current state encoding.
dac_link_lost  out  1  sticky: link dropped while in RUN or DELAY.
dac_dunf_count  out  16  saturating underflow count.

Behaviour:
- All state and outputs are registered.
- Reset values: state IDLE, dac_valid=0, dac_data_en=0, dac_state=0, dac_link_lost=0, dac_dunf_count=0, settle/delay counters 0, trigger history register=1. The history reset value means a trigger held high through reset is not treated as an edge.
- State encoding: IDLE=0, LINK_WAIT=1, ARMED=2, DELAY=3, RUN=4. Unused codes go to IDLE on the next cycle.
- Priority, highest first: dac_rst, then dac_disarm, then all other transitions. dac_disarm in any state gives IDLE on the next cycle.
- IDLE: when dac_arm=1, go to LINK_WAIT, clear the settle counter and clear dac_link_lost.
- LINK_WAIT:
  - Settle counter increments while tx_ready=1 and resets to 0 on any tx_ready=0 cycle.
  - When the counter reaches LINK_SETTLE_CYCLES-1 with tx_ready=1, go to ARMED. ARMED is therefore entered exactly LINK_SETTLE_CYCLES cycles after tx_ready has been continuously high.
- ARMED:
  - If dac_trig_bypass=1, go to RUN on the next cycle.
  - Otherwise a rising edge (dac_trig=1 and history=0, both sampled in cycle T) starts the delay, with dac_trig_delay captured at T:
    - delay=0: RUN at T+1.
    - delay>0: DELAY with counter=delay-1.
  - tx_ready=0 while ARMED: go back to LINK_WAIT, settle counter cleared. dac_link_lost is not set.
- DELAY:
  - If counter=0, go to RUN; otherwise decrement. RUN is therefore entered at exactly T+1+dac_trig_delay.
  - Trigger edges during DELAY are ignored.
  - tx_ready=0: go to IDLE and set dac_link_lost.
- RUN:
  - dac_data_en=1; dac_valid = dac_enable_in, registered, so one cycle of latency on enable changes.
  - tx_ready=0: next cycle IDLE, dac_valid=0, dac_data_en=0, dac_link_lost=1.
- Outside RUN: dac_valid=0 and dac_data_en=0. Both take value 1 / dac_enable_in in the first RUN cycle and drop in the first non-RUN cycle.
- Trigger history register updates every cycle in every state.
- Underflow counter:
  - Increments by 1 in each RUN cycle with dac_dunf=1; dac_dunf is ignored outside RUN.
  - Saturates at 16'hFFFF.
  - dac_dunf_clr zeroes it and wins over a simultaneous increment.
  - Not cleared by arm or disarm.
- dac_arm outside IDLE is ignored. dac_arm and dac_disarm in the same cycle gives IDLE.

Test Plan:
- Reset, then dac_arm with tx_ready=1 and LINK_SETTLE_CYCLES=16 -> dac_state=1 for 16 cycles, then 2. tx_ready low for 1 cycle at count 10 -> ARMED is reached 16 cycles after tx_ready returns high.
- ARMED, dac_trig_delay=5, trigger rises in cycle T -> dac_state=3 from T+1, 4 at T+6. dac_valid=dac_enable_in=2'b11 and dac_data_en=1 from T+6. Repeat with delay=0 -> RUN at T+1.
- dac_trig held high through reset and arm -> no start. A low-then-high trigger afterwards -> start at the specified cycle. dac_trig_bypass=1 in ARMED -> RUN next cycle.
- RUN with tx_ready dropped at cycle C -> at C+1: dac_state=0, dac_valid=0, dac_data_en=0, dac_link_lost=1. Next dac_arm -> dac_link_lost=0.
- RUN with dac_dunf high for 3 cycles -> count=3. dac_dunf_clr coincident with dac_dunf -> count=0. Counter forced near max and dac_dunf held high -> count stops at 16'hFFFF. dac_dunf in IDLE -> no change.
- dac_disarm in each of LINK_WAIT, ARMED, DELAY, RUN -> IDLE next cycle. dac_arm and dac_disarm together in IDLE -> stays IDLE. dac_enable_in changes in RUN -> dac_valid follows one cycle later.
